fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Next-PC sequencer and stall/flush controller for the fetch stage. Each cycle it drives the PC that fetch captures and the fetch `freeze` enable. It arbitrates between sequential advance, branch/jump redirect from execute, hazard stalls and instruction-memory wait. It also emits the squash signal for the decode pipeline register and counts redirects for performance monitoring.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `FLUSH_CYCLES`, default 2, legal range 1..7: bubbles inserted per redirect, counting the redirect cycle.
- `clk` input 1: single clock, all state on posedge.
- `rst` input 1: reset, asynchronous and active-high.
- `stall_i` input 1: hazard-unit stall request.
- `imem_ready_i` input 1: instruction memory data valid this cycle; 0 means wait.
- `redirect_i` input 1: taken branch/jump from execute, single-cycle pulse.
- `redirect_pc_i` input 32: redirect target.
- `pc_o` output 32: PC to fetch `pc_i`; combinational.
- `freeze_o` output 1: to fetch `freeze`; combinational.
- `flush_o` output 1: squash decode register / convert to bubble; combinational.
- `state_o` output 2: current FSM state.
- `redirect_cnt_o` output 16: saturating redirect counter.

## Operation
- Registers:
  - `pc_q`: next sequential PC.
  - `state`: 2-bit FSM state.
  - `fcnt`: 3-bit flush counter.
  - `rcnt`: 16-bit redirect counter.
- `pc_o = redirect_i ? {redirect_pc_i[31:2],2'b00} : pc_q`. Low bits are always forced to 0.
- `freeze_o = !redirect_i & (state != BOOT) & (stall_i | !imem_ready_i)`.
- `flush_o = redirect_i | (state == BOOT) | (state == FLUSH)`.
- State encodings: BOOT=0, RUN=1, STALL=2, FLUSH=3.
- On any posedge where `freeze_o == 0`: `pc_q <= pc_o + 4`, wrapping modulo 2^32 (FFFF_FFFC → 0000_0000).
- When `freeze_o == 1`: `pc_q` and `fcnt` hold.
- Priority is redirect > BOOT > freeze > advance.
- Transitions:
  - BOOT: one cycle after reset release. Fetch loads RESET_PC while the garbage fetch output is squashed. `stall_i` and `imem_ready_i` are ignored. Next state is RUN, or follows the redirect rule if `redirect_i` is high.
  - RUN → STALL when `freeze_o` is 1. STALL → RUN when `freeze_o` is 0.
  - Any state with `redirect_i`: if FLUSH_CYCLES > 1, next state is FLUSH and `fcnt <= FLUSH_CYCLES-2`. Otherwise next state is RUN.
  - FLUSH: on each non-frozen cycle, if `fcnt == 0` go to RUN, else decrement `fcnt`. On a frozen cycle, stay in FLUSH; `flush_o` stays high.
- A new redirect while in FLUSH restarts the count.
- `rcnt` increments on every posedge with `redirect_i` high. It saturates at 16'hFFFF and never wraps.

## Timing
- Reset values:
  - `pc_q = RESET_PC`, `state = BOOT`, `fcnt = 0`, `rcnt = 0`.
  - Outputs during reset with `redirect_i` low: `pc_o = RESET_PC`, `freeze_o = 0`, `flush_o = 1`, `state_o = 0`, `redirect_cnt_o = 0`.
- Reset asserted mid-operation forces all registers to these values immediately, with no clock edge needed.
- Latency:
  - Redirect target reaches fetch on the same posedge as `redirect_i`, so zero added cycles.
  - The first valid target instruction appears at fetch `instr_o` after the following negedge.
- Stall: `freeze_o` follows `stall_i` and `imem_ready_i` combinationally in the same cycle. No cycle is lost on release.
- Redirect coincident with stall or memory wait: the redirect is taken, `freeze_o = 0` and `pc_q <= target+4`.
- `redirect_i` and `redirect_pc_i` must be stable before the posedge. All outputs are glitch-tolerant only; they are not registered.

## Structure
- Shared package / include holds:
  - State encodings `FC_BOOT`, `FC_RUN`, `FC_STALL`, `FC_FLUSH`.
  - Width constants: PC width 32, state width 2, counter width 16.
  - Instruction size constant 4.
- One sub-module: `sat_counter` (parameter WIDTH; inputs `clk`, `rst`, `inc`; output `count`). It is instantiated for `rcnt` and reused by other perf counters.

## Test plan
- Reset release with `stall_i=1` and RESET_PC=0: cycle 0 gives `pc_o=0`, `freeze_o=0`, `flush_o=1`. The next cycles give `pc_o` = 4, 8, 12 with `state_o=RUN`.
- `stall_i` high for 3 cycles at `pc_q=0x10`: `freeze_o=1` and `pc_o` holds `0x10` for 3 cycles with `state_o=STALL`. On release `pc_o=0x14`.
- Redirect to 0x203 during `imem_ready_i=0`, FLUSH_CYCLES=2:
  - Redirect cycle: `pc_o=0x200`, `freeze_o=0`, `flush_o=1`.
  - Next cycle: `flush_o=1`, `state_o=FLUSH`, `pc_o=0x204`.
  - Then `flush_o=0` and `state_o=RUN`, provided memory is ready.
- A second redirect in the FLUSH cycle restarts the flush: `flush_o` stays high for 2 more cycles and `redirect_cnt_o` increments by 2 in total.
- `pc_q=0xFFFF_FFFC`, advance one cycle: `pc_o` wraps to `0x0000_0000`.
- Preload `rcnt=0xFFFE` via 65534 redirects, then 3 more redirects: `redirect_cnt_o` stays at `0xFFFF`. Asserting `rst` mid-run returns it to 0 asynchronously.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared state encodings, widths and helpers for the fetch next-PC sequencer.
package fetch_ctrl_pkg;

    localparam int PC_W    = 32;
    localparam int STATE_W = 2;
    localparam int CNT_W   = 16;
    localparam int FCNT_W  = 3;

    localparam logic [PC_W-1:0] INSTR_BYTES = 32'd4;

    typedef enum logic [STATE_W-1:0] {
        FC_BOOT  = 2'd0,
        FC_RUN   = 2'd1,
        FC_STALL = 2'd2,
        FC_FLUSH = 2'd3
    } fc_state_e;

    // Clears the sub-word offset so fetch only ever sees instruction-aligned PCs.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & ~(INSTR_BYTES - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-control bundle: hazard/memory/redirect inputs and the PC/freeze/flush outputs.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic               stall_i;
    logic               imem_ready_i;
    logic               redirect_i;
    logic [PC_W-1:0]    redirect_pc_i;
    logic [PC_W-1:0]    pc_o;
    logic               freeze_o;
    logic               flush_o;
    logic [STATE_W-1:0] state_o;
    logic [CNT_W-1:0]   redirect_cnt_o;

    // master is the sequencer itself; slave is the pipeline side consuming it.
    modport master (
        input  stall_i, imem_ready_i, redirect_i, redirect_pc_i,
        output pc_o, freeze_o, flush_o, state_o, redirect_cnt_o
    );

    modport slave (
        output stall_i, imem_ready_i, redirect_i, redirect_pc_i,
        input  pc_o, freeze_o, flush_o, state_o, redirect_cnt_o
    );

endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter shared by the performance counters; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Next-PC sequencer and stall/flush controller for the fetch stage.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FC_BOOT  | first cycle after reset; fetch loads RESET_PC, output squashed
// FC_RUN   | sequential advance
// FC_STALL | previous cycle was frozen by hazard stall or memory wait
// FC_FLUSH | post-redirect bubbles still being inserted (fcnt_q remaining)
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    // The redirect cycle is itself the first bubble, so the counter starts two short.
    localparam bit               USE_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [FCNT_W-1:0] FCNT_INIT = USE_FLUSH ? FCNT_W'(FLUSH_CYCLES - 2) : '0;

    fc_state_e         state_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic [PC_W-1:0]   pc_sel;
    logic              freeze;
    logic              flush;

    always_comb begin
        pc_sel = bus.redirect_i ? align_pc(bus.redirect_pc_i) : pc_q;
        freeze = !bus.redirect_i && (state_q != FC_BOOT) &&
                 (bus.stall_i || !bus.imem_ready_i);
        flush  = bus.redirect_i || (state_q == FC_BOOT) || (state_q == FC_FLUSH);
        pc_d   = pc_sel + INSTR_BYTES;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= FC_BOOT;
            fcnt_q  <= '0;
        end else begin
            if (!freeze) begin
                pc_q <= pc_d;
            end

            if (bus.redirect_i) begin
                state_q <= USE_FLUSH ? FC_FLUSH : FC_RUN;
                fcnt_q  <= FCNT_INIT;
            end else begin
                case (state_q)
                    FC_BOOT:  state_q <= FC_RUN;
                    FC_RUN:   if (freeze) state_q <= FC_STALL;
                    FC_STALL: if (!freeze) state_q <= FC_RUN;
                    FC_FLUSH: begin
                        if (!freeze) begin
                            if (fcnt_q == '0) begin
                                state_q <= FC_RUN;
                            end else begin
                                fcnt_q <= fcnt_q - FCNT_W'(1);
                            end
                        end
                    end
                    default:  state_q <= FC_BOOT;
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_rcnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.redirect_i),
        .count (bus.redirect_cnt_o)
    );

    assign bus.pc_o     = pc_sel;
    assign bus.freeze_o = freeze;
    assign bus.flush_o  = flush;
    assign bus.state_o  = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, random stimulus vs. a
// bubble-count reference model on two parameterisations, and counter saturation.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [31:0] RPC_A = 32'h0000_0000;
    localparam int          FC_A  = 2;
    localparam logic [31:0] RPC_B = 32'h0000_1000;
    localparam int          FC_B  = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, rdy, red;
    logic [31:0] tgt;

    always #5 clk = ~clk;

    fetch_ctrl_if ifa ();
    fetch_ctrl_if ifb ();

    assign ifa.stall_i       = stall;
    assign ifa.imem_ready_i  = rdy;
    assign ifa.redirect_i    = red;
    assign ifa.redirect_pc_i = tgt;
    assign ifb.stall_i       = stall;
    assign ifb.imem_ready_i  = rdy;
    assign ifb.redirect_i    = red;
    assign ifb.redirect_pc_i = tgt;

    fetch_ctrl #(.RESET_PC(RPC_A), .FLUSH_CYCLES(FC_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    fetch_ctrl #(.RESET_PC(RPC_B), .FLUSH_CYCLES(FC_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Reference model: tracks pending bubbles and whether the last cycle was frozen.
    typedef struct {
        logic [31:0] pc;
        bit          boot;
        int          bubbles;
        bit          stalled;
        int          rcnt;
    } mdl_t;

    typedef struct {
        logic        s, r, rd;
        logic [31:0] t;
        logic [31:0] pc;
        logic        frz, fl;
        logic [1:0]  st;
        logic [15:0] cnt;
    } vec_t;

    mdl_t ma, mb;
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic mdl_t mdl_reset(input logic [31:0] rpc);
        mdl_t n;
        n.pc = rpc; n.boot = 1'b1; n.bubbles = 0; n.stalled = 1'b0; n.rcnt = 0;
        return n;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input int fc, input logic s, r, rd,
                                      input logic [31:0] t);
        mdl_t n;
        bit   frz;
        n   = m;
        frz = !rd && !m.boot && (s || !r);
        if (!frz) n.pc = (rd ? (t & ~32'h3) : m.pc) + 32'd4;
        if (rd) begin
            n.bubbles = fc - 1; n.stalled = 1'b0; n.boot = 1'b0;
        end else if (m.boot) begin
            n.boot = 1'b0; n.stalled = 1'b0;
        end else if (m.bubbles > 0) begin
            if (!frz) n.bubbles = m.bubbles - 1;
        end else begin
            n.stalled = frz;
        end
        if (rd && m.rcnt < 65535) n.rcnt = m.rcnt + 1;
        return n;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_one(input string tag, input mdl_t m, input logic [31:0] pc,
                             input logic frz, input logic fl, input logic [1:0] st,
                             input logic [15:0] cnt);
        logic [31:0] e_pc;
        logic        e_frz, e_fl;
        logic [1:0]  e_st;
        e_pc  = red ? (tgt & ~32'h3) : m.pc;
        e_frz = !red && !m.boot && (stall || !rdy);
        e_fl  = red || m.boot || (m.bubbles > 0);
        e_st  = m.boot ? 2'd0 : (m.bubbles > 0) ? 2'd3 : m.stalled ? 2'd2 : 2'd1;
        cmp({tag, ".pc"}, pc, e_pc);
        cmp({tag, ".freeze"}, {31'd0, frz}, {31'd0, e_frz});
        cmp({tag, ".flush"}, {31'd0, fl}, {31'd0, e_fl});
        cmp({tag, ".state"}, {30'd0, st}, {30'd0, e_st});
        cmp({tag, ".rcnt"}, {16'd0, cnt}, m.rcnt);
    endtask

    task automatic check_model();
        check_one("A", ma, ifa.pc_o, ifa.freeze_o, ifa.flush_o, ifa.state_o, ifa.redirect_cnt_o);
        check_one("B", mb, ifb.pc_o, ifb.freeze_o, ifb.flush_o, ifb.state_o, ifb.redirect_cnt_o);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            ma = mdl_next(ma, FC_A, stall, rdy, red, tgt);
            mb = mdl_next(mb, FC_B, stall, rdy, red, tgt);
        end
    endtask

    task automatic cycle(input logic s, input logic r, input logic rd, input logic [31:0] t,
                         input bit chk);
        @(negedge clk);
        stall = s; rdy = r; red = rd; tgt = t;
        #1;
        if (chk) check_model();
        tick();
    endtask

    // Reset asserted between edges: outputs must return to reset values with no clock.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        ma = mdl_reset(RPC_A);
        mb = mdl_reset(RPC_B);
        check_model();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    function automatic void addv(input logic s, r, rd, input logic [31:0] t, input logic [31:0] pc,
                                 input logic frz, fl, input logic [1:0] st, input logic [15:0] cnt);
        vec_t v;
        v.s = s; v.r = r; v.rd = rd; v.t = t; v.pc = pc;
        v.frz = frz; v.fl = fl; v.st = st; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //   s  r  rd tgt           pc            frz fl st cnt
        addv(1, 1, 0, 32'h0,        32'h0,        0, 1, 0, 0);
        addv(0, 1, 0, 32'h0,        32'h4,        0, 0, 1, 0);
        addv(0, 1, 0, 32'h0,        32'h8,        0, 0, 1, 0);
        addv(0, 1, 0, 32'h0,        32'hC,        0, 0, 1, 0);
        addv(1, 1, 0, 32'h0,        32'h10,       1, 0, 1, 0);
        addv(1, 1, 0, 32'h0,        32'h10,       1, 0, 2, 0);
        addv(1, 1, 0, 32'h0,        32'h10,       1, 0, 2, 0);
        addv(0, 1, 0, 32'h0,        32'h10,       0, 0, 2, 0);
        addv(0, 1, 0, 32'h0,        32'h14,       0, 0, 1, 0);
        addv(0, 0, 1, 32'h203,      32'h200,      0, 1, 1, 0);
        addv(0, 1, 0, 32'h0,        32'h204,      0, 1, 3, 1);
        addv(0, 1, 0, 32'h0,        32'h208,      0, 0, 1, 1);
        addv(0, 1, 1, 32'h400,      32'h400,      0, 1, 1, 1);
        addv(0, 1, 1, 32'h500,      32'h500,      0, 1, 3, 2);
        addv(0, 1, 0, 32'h0,        32'h504,      0, 1, 3, 3);
        addv(0, 1, 0, 32'h0,        32'h508,      0, 0, 1, 3);
        addv(1, 1, 1, 32'h600,      32'h600,      0, 1, 1, 3);
        addv(0, 0, 0, 32'h0,        32'h604,      1, 1, 3, 4);
        addv(0, 1, 0, 32'h0,        32'h604,      0, 1, 3, 4);
        addv(0, 1, 0, 32'h0,        32'h608,      0, 0, 1, 4);
        addv(0, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 0, 1, 1, 4);
        addv(0, 1, 0, 32'h0,        32'hFFFF_FFFC, 0, 1, 3, 5);
        addv(0, 1, 0, 32'h0,        32'h0,        0, 0, 1, 5);

        rst = 1'b1; stall = 1'b1; rdy = 1'b1; red = 1'b0; tgt = 32'h0;
        ma = mdl_reset(RPC_A);
        mb = mdl_reset(RPC_B);
        #3;
        cmp("rst.pc", ifa.pc_o, RPC_A);
        cmp("rst.freeze", {31'd0, ifa.freeze_o}, 32'd0);
        cmp("rst.flush", {31'd0, ifa.flush_o}, 32'd1);
        cmp("rst.state", {30'd0, ifa.state_o}, 32'd0);
        cmp("rst.rcnt", {16'd0, ifa.redirect_cnt_o}, 32'd0);
        cmp("rst.pc_b", ifb.pc_o, RPC_B);
        @(posedge clk);
        #2;
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            stall = vecs[i].s; rdy = vecs[i].r; red = vecs[i].rd; tgt = vecs[i].t;
            #1;
            check_model();
            cmp($sformatf("vec%0d.pc", i), ifa.pc_o, vecs[i].pc);
            cmp($sformatf("vec%0d.freeze", i), {31'd0, ifa.freeze_o}, {31'd0, vecs[i].frz});
            cmp($sformatf("vec%0d.flush", i), {31'd0, ifa.flush_o}, {31'd0, vecs[i].fl});
            cmp($sformatf("vec%0d.state", i), {30'd0, ifa.state_o}, {30'd0, vecs[i].st});
            cmp($sformatf("vec%0d.rcnt", i), {16'd0, ifa.redirect_cnt_o}, {16'd0, vecs[i].cnt});
            tick();
        end

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 5) == 0), $urandom, 1'b1);
            end
        end

        pulse_reset();
        for (int n = 0; n < 65534; n++) begin
            cycle(($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0), 1'b1, $urandom, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            stall = 1'b0; rdy = 1'b1; red = 1'b1; tgt = $urandom;
            #1;
            check_model();
            cmp($sformatf("sat%0d.rcnt", k), {16'd0, ifa.redirect_cnt_o},
                (k == 0) ? 32'h0000_FFFE : 32'h0000_FFFF);
            tick();
        end
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        cmp("sat_hold.rcnt", {16'd0, ifa.redirect_cnt_o}, 32'h0000_FFFF);

        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        cmp("async_rst.rcnt", {16'd0, ifa.redirect_cnt_o}, 32'd0);
        cmp("async_rst.state", {30'd0, ifa.state_o}, 32'd0);
        cmp("async_rst.pc", ifa.pc_o, RPC_A);
        cmp("async_rst.flush", {31'd0, ifa.flush_o}, 32'd1);
        cmp("async_rst.rcnt_b", {16'd0, ifb.redirect_cnt_o}, 32'd0);
        ma = mdl_reset(RPC_A);
        mb = mdl_reset(RPC_B);
        @(posedge clk);
        #2;
        rst = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
